// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory and IF stage.
// master = prefetch unit side, slave = memory/IF-stage side.
interface instr_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic                      redirect;
  logic [15:0]               redirect_pc;
  logic                      mem_req;
  logic [15:0]               mem_addr;
  logic                      mem_ack;
  logic [15:0]               mem_rdata;
  logic                      pop;
  logic                      inst_valid;
  logic [15:0]               inst;
  logic [15:0]               inst_pc;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, pop,
    output mem_req, mem_addr, inst_valid, inst, inst_pc, count
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, pop,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, count
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding req/ack fetch at a time,
// {PC, instruction} FIFO toward IF, redirect flushes and restarts fetching.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input logic                    clk,
  input logic                    rst_n,
  instr_prefetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic             mem_req_q, mem_req_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      pc_mem_q  [DEPTH];
  logic [15:0]      pc_mem_d  [DEPTH];
  logic [15:0]      ins_mem_q [DEPTH];
  logic [15:0]      ins_mem_d [DEPTH];
  logic             wr_en;
  logic             pop_en;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;

    wr_en  = (state_q == REQ) && bus.mem_ack && !bus.redirect;
    pop_en = bus.pop && (count_q != '0) && !bus.redirect;

    if (wr_en) begin
      pc_mem_d[wr_ptr_q]  = fetch_pc_q;
      ins_mem_d[wr_ptr_q] = bus.mem_rdata;
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop_en);

    if (bus.redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = bus.redirect_pc;
      // A request still waiting for its ack must be drained before restarting.
      if ((state_q != IDLE) && !bus.mem_ack) begin
        state_d = DISCARD;
      end else begin
        state_d = REQ;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q < FULL) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = (count_d < FULL) ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (bus.mem_ack) begin
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Address only moves when a fresh request starts; DISCARD/IDLE hold it.
    mem_req_d  = (state_d != IDLE);
    mem_addr_d = (state_d == REQ) ? fetch_pc_d : mem_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = ins_mem_q[rd_ptr_q];
  assign bus.inst_pc    = pc_mem_q[rd_ptr_q];
  assign bus.count      = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: queue-based reference model checked every
// cycle, plus directed scenarios with hand-derived literal expectations.
module tb_instr_prefetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_STEP  = 16'h0001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_prefetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Memory responder: acks mem_lat idle cycles after a request is seen.
  int unsigned mem_lat  = 0;
  int unsigned wait_cnt = 0;
  logic        ovr_en   = 1'b0;
  logic [15:0] ovr_data = '0;

  task automatic tick();
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.pop      = 1'b0;
    if (rst_n && bus.mem_req) begin
      if (wait_cnt >= mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = ovr_en ? ovr_data : mem_word(bus.mem_addr);
        ovr_en        = 1'b0;
        wait_cnt      = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end
  endtask

  // Reference model: queue of {pc, word}, one pending-fetch record.
  logic [31:0] m_q[$];
  logic [15:0] m_fetch_pc = RESET_PC;
  logic [15:0] m_addr     = RESET_PC;
  bit          m_req      = 1'b0;
  bit          m_discard  = 1'b0;
  int unsigned m_pre;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_fetch_pc = RESET_PC;
        m_addr     = RESET_PC;
        m_req      = 1'b0;
        m_discard  = 1'b0;
      end else if (bus.redirect) begin
        m_q.delete();
        m_fetch_pc = bus.redirect_pc;
        if (m_req && !bus.mem_ack) begin
          m_discard = 1'b1;
        end else begin
          m_req     = 1'b1;
          m_discard = 1'b0;
          m_addr    = bus.redirect_pc;
        end
      end else begin
        m_pre = m_q.size();
        if (bus.pop && m_pre > 0) void'(m_q.pop_front());
        if (!m_req) begin
          if (m_pre < DEPTH) begin
            m_req  = 1'b1;
            m_addr = m_fetch_pc;
          end
        end else if (bus.mem_ack) begin
          if (m_discard) begin
            m_discard = 1'b0;
            m_addr    = m_fetch_pc;
          end else begin
            m_q.push_back({m_fetch_pc, bus.mem_rdata});
            m_fetch_pc = m_fetch_pc + PC_STEP;
            if (m_q.size() < DEPTH) m_addr = m_fetch_pc;
            else m_req = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("model mem_req", bus.mem_req, m_req);
        if (m_req) check("model mem_addr", bus.mem_addr, m_addr);
        check("model count", bus.count, m_q.size());
        check("model inst_valid", bus.inst_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
          check("model inst_pc", bus.inst_pc, m_q[0][31:16]);
          check("model inst", bus.inst, m_q[0][15:0]);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " mem_req"}, bus.mem_req, 1'b0);
    check({tag, " mem_addr"}, bus.mem_addr, RESET_PC);
    check({tag, " inst_valid"}, bus.inst_valid, 1'b0);
    check({tag, " inst"}, bus.inst, 16'h0000);
    check({tag, " inst_pc"}, bus.inst_pc, 16'h0000);
    check({tag, " count"}, bus.count, 0);
  endtask

  initial begin
    int n;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.pop         = 1'b0;

    // Reset state and initial fill with zero-wait memory
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
    check("t1 req after first edge", bus.mem_req, 1'b1);
    check("t1 first addr", bus.mem_addr, RESET_PC);
    n = 0;
    while (!(bus.count == 4 && !bus.mem_req) && n < 20) begin
      tick();
      n++;
    end
    check("t1 fill cycles", n, 4);
    check("t1 count", bus.count, 4);
    check("t1 mem_req", bus.mem_req, 1'b0);
    check("t1 head pc", bus.inst_pc, 16'h0000);
    check("t1 head inst", bus.inst, mem_word(16'h0000));

    // Continuous pop from a full queue
    for (int i = 0; i < 12; i++) begin
      check("t2 pop pc", bus.inst_pc, 16'(i));
      check("t2 pop inst", bus.inst, mem_word(16'(i)));
      bus.pop = 1'b1;
      tick();
    end
    check("t2 steady count", bus.count, 2);
    check("t2 steady req", bus.mem_req, 1'b1);

    // Redirect while the fetch of 0x0002 is still outstanding
    mem_lat = 3;
    do_reset();
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 16'h0002) && n < 40) begin
      tick();
      n++;
    end
    check("t3 reached addr 2", bus.mem_addr, 16'h0002);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    ovr_en          = 1'b1;
    ovr_data        = 16'hDEAD;
    n = 0;
    do begin
      tick();
      n++;
      check("t3 req held", bus.mem_req, 1'b1);
    end while (bus.mem_addr != 16'h0040 && n < 20);
    check("t3 restart addr", bus.mem_addr, 16'h0040);
    check("t3 flushed count", bus.count, 0);
    n = 0;
    while (!bus.inst_valid && n < 20) begin
      tick();
      n++;
    end
    check("t3 first pc", bus.inst_pc, 16'h0040);
    check("t3 first inst", bus.inst, mem_word(16'h0040));

    // Redirect + ack + pop in one cycle with count=2
    mem_lat = 0;
    do_reset();
    n = 0;
    while (bus.count != 2 && n < 20) begin
      tick();
      n++;
    end
    check("t4 setup addr", bus.mem_addr, 16'h0002);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    bus.pop         = 1'b1;
    tick();
    check("t4 count", bus.count, 0);
    check("t4 inst_valid", bus.inst_valid, 1'b0);
    check("t4 mem_req", bus.mem_req, 1'b1);
    check("t4 mem_addr", bus.mem_addr, 16'h0100);

    // Redirect to the top of the address space and wrap
    n = 0;
    while (bus.count != 4 && n < 20) begin
      tick();
      n++;
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    tick();
    check("t5 flushed", bus.count, 0);
    n = 0;
    while (!(bus.count == 4 && !bus.mem_req) && n < 20) begin
      tick();
      n++;
    end
    check("t5 head pc", bus.inst_pc, 16'hFFFF);
    bus.pop = 1'b1;
    tick();
    check("t5 wrapped pc", bus.inst_pc, 16'h0000);
    check("t5 wrapped inst", bus.inst, mem_word(16'h0000));

    // Asynchronous reset while count=3 with a request outstanding
    mem_lat = 2;
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.count == 3 && bus.mem_req) && n < 40);
    check("t6 setup count", bus.count, 3);
    rst_n = 1'b0;
    #1;
    check_reset_values("t6 async reset");
    mem_lat = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6 restart req", bus.mem_req, 1'b1);
    check("t6 restart addr", bus.mem_addr, RESET_PC);
    n = 0;
    while (!bus.inst_valid && n < 20) begin
      tick();
      n++;
    end
    check("t6 first pc", bus.inst_pc, RESET_PC);
    check("t6 first inst", bus.inst, mem_word(RESET_PC));

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
